// File: rtl/pcie_pkg.sv
// Shared PCIe ingress definitions.
// Contents:
//   - bus width constants;
//   - the pre-parsed TLP header record (tlp_head_t);
//   - the compact read-request record handed to register owners (rdreq_info_t);
//   - the dispatch target enum and the BAR-offset register code constants.
package pcie_pkg;

    localparam int unsigned PCIE_DATA_WIDTH = 256;
    localparam int unsigned PCIE_DATA_KW    = PCIE_DATA_WIDTH / 32;

    typedef struct packed {
        logic [9:0]  len;       // length in DW
        logic [3:0]  first_be;
        logic [3:0]  last_be;
        logic [7:0]  tag;
        logic [15:0] req_id;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [63:0] addr;      // BAR-relative byte address
    } tlp_head_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] req_id;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [6:0]  lower_addr;
        logic [3:0]  code;
        logic [3:0]  channel;
    } rdreq_info_t;

    typedef enum logic [1:0] {
        TGT_TX,
        TGT_RX,
        TGT_REG,
        TGT_ERR
    } rd_tgt_e;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } disp_state_e;

    // Register codes in the BAR offset field
    localparam logic [3:0] RD_TX_LEN   = 4'b1000;
    localparam logic [3:0] RD_TX_PTR   = 4'b1001;
    localparam logic [3:0] RD_GLB_CTRL = 4'b1010;
    localparam logic [3:0] RD_GLB_STAT = 4'b1011;
    localparam logic [3:0] RD_GLB_IRQ  = 4'b1100;
    localparam logic [3:0] RD_RX_STAT  = 4'b1101;
    localparam logic [3:0] RD_TX_STAT  = 4'b1110;
    localparam logic [3:0] RD_GLB_ID   = 4'b1111;

endpackage

// File: rtl/ingress_rdreq_dispatch_if.sv
// Handshake bundles around the read-request dispatcher.
//   rdreq_if    : request stream from the ingress pre-parser.
//                 master = pre-parser, slave = dispatcher.
//                 Signals: data/keep (ignored for reads), meta, valid, rdy.
//   rd_disp_if  : dispatch to register owners.
//                 master = dispatcher, slave = targets.
//                 Signals: shared rd_info, per-target valid/ready
//                 (TX/RX channels one-hot, global regs, UR error path).
interface rdreq_if;
    import pcie_pkg::*;

    logic [PCIE_DATA_WIDTH-1:0] rdreq_data;
    logic [PCIE_DATA_KW-1:0]    rdreq_keep;
    tlp_head_t                  rdreq_meta;
    logic                       rdreq_valid;
    logic                       rdreq_rdy;

    modport master (
        output rdreq_data, rdreq_keep, rdreq_meta, rdreq_valid,
        input  rdreq_rdy
    );
    modport slave (
        input  rdreq_data, rdreq_keep, rdreq_meta, rdreq_valid,
        output rdreq_rdy
    );
endinterface

interface rd_disp_if #(
    parameter int unsigned CHANNEL_NUM = 12
);
    import pcie_pkg::*;

    rdreq_info_t            rd_info;
    logic [CHANNEL_NUM-1:0] tx_rd_valid;
    logic [CHANNEL_NUM-1:0] tx_rd_ready;
    logic [CHANNEL_NUM-1:0] rx_rd_valid;
    logic [CHANNEL_NUM-1:0] rx_rd_ready;
    logic                   reg_rd_valid;
    logic                   reg_rd_ready;
    logic                   err_rd_valid;
    logic                   err_rd_ready;

    modport master (
        output rd_info, tx_rd_valid, rx_rd_valid, reg_rd_valid, err_rd_valid,
        input  tx_rd_ready, rx_rd_ready, reg_rd_ready, err_rd_ready
    );
    modport slave (
        input  rd_info, tx_rd_valid, rx_rd_valid, reg_rd_valid, err_rd_valid,
        output tx_rd_ready, rx_rd_ready, reg_rd_ready, err_rd_ready
    );
endinterface

// File: rtl/ingress_rdreq_dispatch_decode.sv
// Combinational BAR-offset / length decode for single-beat memory reads.
// Ports:
//   meta_i : pre-parsed TLP header.
//   tgt_o  : owner of the addressed register (TX / RX / REG / ERR).
//   chan_o : channel field of the offset.
//   code_o : register code field of the offset.
// Offset layout: {channel[3:0], code[3:0], OFS_LSB zero bits}.
module rdreq_addr_decode
    import pcie_pkg::*;
#(
    parameter int unsigned CHANNEL_NUM = 12,
    parameter int unsigned OFS_LSB     = 2
) (
    input  tlp_head_t  meta_i,
    output rd_tgt_e    tgt_o,
    output logic [3:0] chan_o,
    output logic [3:0] code_o
);

    logic ch_ok;
    logic unused_meta;

    assign code_o      = meta_i.addr[OFS_LSB +: 4];
    assign chan_o      = meta_i.addr[OFS_LSB + 4 +: 4];
    assign ch_ok       = (32'(chan_o) < CHANNEL_NUM);
    assign unused_meta = ^meta_i;

    always_comb begin
        tgt_o = TGT_ERR;
        if (meta_i.len == 10'd1 && meta_i.first_be != 4'b0000) begin
            unique case (code_o)
                RD_TX_LEN, RD_TX_PTR, RD_TX_STAT:
                    tgt_o = ch_ok ? TGT_TX : TGT_ERR;
                RD_RX_STAT:
                    tgt_o = ch_ok ? TGT_RX : TGT_ERR;
                RD_GLB_CTRL, RD_GLB_STAT, RD_GLB_IRQ, RD_GLB_ID:
                    tgt_o = TGT_REG;
                default:
                    tgt_o = TGT_ERR;
            endcase
        end
    end

endmodule

// File: rtl/ingress_rdreq_dispatch.sv
// Read-request dispatcher in the PCIe ingress path.
// Accepts single-beat memory-read headers, decodes the BAR offset, holds one
// request and presents it to exactly one owner (TX channel, RX channel,
// global registers or UR error path). Outstanding reads are counted from
// dispatch until the completion generator pulses cpl_done; intake stalls at
// MAX_OUTST.
// Ports:
//   clk, rst  : clock, synchronous active-low reset.
//   rdreq     : request stream (slave side).
//   disp      : dispatch bundle (master side).
//   cpl_done  : one-cycle pulse per completion sent.
//   outst_cnt : current outstanding read count.
module ingress_rdreq_dispatch
    import pcie_pkg::*;
#(
    parameter int unsigned CHANNEL_NUM = 12,
    parameter int unsigned MAX_OUTST   = 4,
    parameter int unsigned OFS_LSB     = 2
) (
    input  logic       clk,
    input  logic       rst,
    rdreq_if.slave     rdreq,
    rd_disp_if.master  disp,
    input  logic       cpl_done,
    output logic [3:0] outst_cnt
);

    disp_state_e state_q, state_d;
    rdreq_info_t info_q, info_d;
    rd_tgt_e     tgt_q, tgt_d;
    logic [3:0]  cnt_q, cnt_d;

    rd_tgt_e     dec_tgt;
    logic [3:0]  dec_chan;
    logic [3:0]  dec_code;

    logic                   rdy;
    logic                   accept;
    logic                   dispatch;
    logic                   cpl_dec;
    logic                   hold_vld;
    logic [CHANNEL_NUM-1:0] chan_onehot;
    logic [CHANNEL_NUM-1:0] tx_vld, rx_vld;
    logic                   reg_vld, err_vld;
    logic                   unused_rdreq;

    rdreq_addr_decode #(
        .CHANNEL_NUM (CHANNEL_NUM),
        .OFS_LSB     (OFS_LSB)
    ) u_dec (
        .meta_i (rdreq.rdreq_meta),
        .tgt_o  (dec_tgt),
        .chan_o (dec_chan),
        .code_o (dec_code)
    );

    // Data and keep carry nothing for reads
    assign unused_rdreq = ^{rdreq.rdreq_data, rdreq.rdreq_keep};

    assign hold_vld = (state_q == ST_HOLD);
    // Gated with rst so the pre-parser sees no ready before the first reset edge
    assign rdy      = rst && !hold_vld && (32'(cnt_q) < MAX_OUTST);
    assign accept   = rdreq.rdreq_valid && rdy;
    // Completions at zero count have nothing to retire
    assign cpl_dec  = cpl_done && (cnt_q != 4'd0);

    always_comb begin
        chan_onehot = '0;
        for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
            chan_onehot[i] = (32'(info_q.channel) == i);
        end
        tx_vld  = (hold_vld && tgt_q == TGT_TX) ? chan_onehot : '0;
        rx_vld  = (hold_vld && tgt_q == TGT_RX) ? chan_onehot : '0;
        reg_vld = hold_vld && (tgt_q == TGT_REG);
        err_vld = hold_vld && (tgt_q == TGT_ERR);
    end

    // Only the selected target's ready can complete the handshake
    assign dispatch = (|(tx_vld & disp.tx_rd_ready))
                    | (|(rx_vld & disp.rx_rd_ready))
                    | (reg_vld & disp.reg_rd_ready)
                    | (err_vld & disp.err_rd_ready);

    always_comb begin
        state_d = state_q;
        info_d  = info_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d           = ST_HOLD;
                    info_d.tag        = rdreq.rdreq_meta.tag;
                    info_d.req_id     = rdreq.rdreq_meta.req_id;
                    info_d.tc         = rdreq.rdreq_meta.tc;
                    info_d.attr       = rdreq.rdreq_meta.attr;
                    info_d.lower_addr = rdreq.rdreq_meta.addr[6:0];
                    info_d.code       = dec_code;
                    info_d.channel    = dec_chan;
                    tgt_d             = dec_tgt;
                end
            end
            ST_HOLD: begin
                if (dispatch) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A dispatch and a completion in the same cycle cancel out
        unique case ({dispatch, cpl_dec})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            info_q  <= '0;
            tgt_q   <= TGT_TX;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            info_q  <= info_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rdreq.rdreq_rdy   = rdy;
    assign disp.rd_info      = info_q;
    assign disp.tx_rd_valid  = tx_vld;
    assign disp.rx_rd_valid  = rx_vld;
    assign disp.reg_rd_valid = reg_vld;
    assign disp.err_rd_valid = err_vld;
    assign outst_cnt         = cnt_q;

endmodule

// File: tb/tb_ingress_rdreq_dispatch.sv
// Directed bench for ingress_rdreq_dispatch (CHANNEL_NUM=12, MAX_OUTST=4,
// OFS_LSB=2). Inputs change and outputs are sampled 1 time unit after each
// rising edge.
module tb_ingress_rdreq_dispatch;
    import pcie_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpl_done;
    logic [3:0] outst_cnt;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    rdreq_if                      u_rdreq ();
    rd_disp_if #(.CHANNEL_NUM(12)) u_disp ();

    ingress_rdreq_dispatch #(
        .CHANNEL_NUM (12),
        .MAX_OUTST   (4),
        .OFS_LSB     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdreq     (u_rdreq),
        .disp      (u_disp),
        .cpl_done  (cpl_done),
        .outst_cnt (outst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_valids(input string tag, input logic [11:0] tx, input logic [11:0] rx,
                              input logic rg, input logic er);
        chk({tag, ".tx"},  64'(u_disp.tx_rd_valid),  64'(tx));
        chk({tag, ".rx"},  64'(u_disp.rx_rd_valid),  64'(rx));
        chk({tag, ".reg"}, 64'(u_disp.reg_rd_valid), 64'(rg));
        chk({tag, ".err"}, 64'(u_disp.err_rd_valid), 64'(er));
    endtask

    function automatic tlp_head_t mk(input logic [9:0] len, input logic [3:0] be,
                                     input logic [3:0] ch, input logic [3:0] code,
                                     input logic [7:0] tag);
        tlp_head_t h;
        h          = '0;
        h.len      = len;
        h.first_be = be;
        h.tag      = tag;
        h.req_id   = 16'hBEEF;
        h.tc       = 3'd2;
        h.attr     = 2'b01;
        h.addr     = {54'd0, ch, code, 2'b00};
        return h;
    endfunction

    // Present one request; ready must already be high in this cycle
    task automatic accept(input string tag, input tlp_head_t h);
        u_rdreq.rdreq_meta  = h;
        u_rdreq.rdreq_valid = 1'b1;
        chk({tag, ".rdy_at_accept"}, 64'(u_rdreq.rdreq_rdy), 64'd1);
        tick;
        u_rdreq.rdreq_valid = 1'b0;
    endtask

    task automatic cpl_pulse;
        cpl_done = 1'b1;
        tick;
        cpl_done = 1'b0;
    endtask

    initial begin
        rdreq_info_t exp_info;

        rst                  = 1'b0;
        cpl_done             = 1'b0;
        u_rdreq.rdreq_data   = {8{32'hDEAD_BEEF}};
        u_rdreq.rdreq_keep   = '1;
        u_rdreq.rdreq_meta   = '0;
        u_rdreq.rdreq_valid  = 1'b0;
        u_disp.tx_rd_ready   = '0;
        u_disp.rx_rd_ready   = '0;
        u_disp.reg_rd_ready  = 1'b0;
        u_disp.err_rd_ready  = 1'b0;

        // Reset
        #2;
        chk("rst.rdy_pre_edge", 64'(u_rdreq.rdreq_rdy), 64'd0);
        tick;
        tick;
        chk("rst.rdy", 64'(u_rdreq.rdreq_rdy), 64'd0);
        chk("rst.cnt", 64'(outst_cnt), 64'd0);
        chk_valids("rst", 12'h000, 12'h000, 1'b0, 1'b0);
        chk("rst.info", 64'(u_disp.rd_info), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst.rdy_after_release", 64'(u_rdreq.rdreq_rdy), 64'd1);

        // TX ch3 code 1000, ready low for 5 cycles
        accept("tx3", mk(10'd1, 4'hF, 4'd3, RD_TX_LEN, 8'h5A));
        exp_info = '{tag: 8'h5A, req_id: 16'hBEEF, tc: 3'd2, attr: 2'd1,
                     lower_addr: 7'h60, code: 4'h8, channel: 4'h3};
        for (int k = 0; k < 5; k++) begin
            chk_valids("tx3.stall", 12'h008, 12'h000, 1'b0, 1'b0);
            chk("tx3.info", 64'(u_disp.rd_info), 64'(exp_info));
            chk("tx3.tag", 64'(u_disp.rd_info.tag), 64'h5A);
            chk("tx3.rdy_low", 64'(u_rdreq.rdreq_rdy), 64'd0);
            chk("tx3.cnt_hold", 64'(outst_cnt), 64'd0);
            tick;
        end
        u_disp.tx_rd_ready = '1;
        tick;
        u_disp.tx_rd_ready = '0;
        chk_valids("tx3.done", 12'h000, 12'h000, 1'b0, 1'b0);
        chk("tx3.cnt", 64'(outst_cnt), 64'd1);
        chk("tx3.rdy_back", 64'(u_rdreq.rdreq_rdy), 64'd1);

        // REG: code 1011 ch7, ready high before valid
        u_disp.reg_rd_ready = 1'b1;
        accept("reg", mk(10'd1, 4'h1, 4'd7, RD_GLB_STAT, 8'h11));
        chk_valids("reg", 12'h000, 12'h000, 1'b1, 1'b0);
        chk("reg.chan", 64'(u_disp.rd_info.channel), 64'd7);
        tick;
        u_disp.reg_rd_ready = 1'b0;
        chk_valids("reg.done", 12'h000, 12'h000, 1'b0, 1'b0);
        chk("reg.cnt", 64'(outst_cnt), 64'd2);

        // RX code with out-of-range channel 13 -> ERR
        u_disp.err_rd_ready = 1'b1;
        accept("rx13", mk(10'd1, 4'hF, 4'd13, RD_RX_STAT, 8'h22));
        chk_valids("rx13", 12'h000, 12'h000, 1'b0, 1'b1);
        tick;
        chk("rx13.cnt", 64'(outst_cnt), 64'd3);

        cpl_pulse;
        chk("cpl.cnt", 64'(outst_cnt), 64'd2);

        // Len 2 -> ERR; dispatch coincident with cpl_done at count 2
        accept("len2", mk(10'd2, 4'hF, 4'd0, RD_TX_LEN, 8'h33));
        chk_valids("len2", 12'h000, 12'h000, 1'b0, 1'b1);
        cpl_done = 1'b1;
        tick;
        cpl_done = 1'b0;
        chk("len2.cnt_same", 64'(outst_cnt), 64'd2);

        // BE 0 -> ERR
        accept("be0", mk(10'd1, 4'h0, 4'd1, RD_TX_PTR, 8'h44));
        chk_valids("be0", 12'h000, 12'h000, 1'b0, 1'b1);
        tick;
        u_disp.err_rd_ready = 1'b0;
        chk("be0.cnt", 64'(outst_cnt), 64'd3);

        // RX ch5 fills the counter
        accept("rx5", mk(10'd1, 4'hF, 4'd5, RD_RX_STAT, 8'h55));
        chk_valids("rx5", 12'h000, 12'h020, 1'b0, 1'b0);
        u_disp.rx_rd_ready = '1;
        tick;
        u_disp.rx_rd_ready = '0;
        chk("rx5.cnt_full", 64'(outst_cnt), 64'd4);
        chk("rx5.rdy_full", 64'(u_rdreq.rdreq_rdy), 64'd0);

        // Drain, then one extra completion at zero
        for (int k = 0; k < 4; k++) cpl_pulse;
        chk("drain.cnt", 64'(outst_cnt), 64'd0);
        cpl_pulse;
        chk("drain.cnt_floor", 64'(outst_cnt), 64'd0);
        chk("drain.rdy", 64'(u_rdreq.rdreq_rdy), 64'd1);

        // Four back-to-back TX reads, channels 8..11, all readies high
        u_disp.tx_rd_ready = '1;
        for (int i = 0; i < 4; i++) begin
            logic [11:0] exp_tx;
            exp_tx = 12'h001 << (8 + i);
            accept("b2b", mk(10'd1, 4'hF, 4'(8 + i), (i == 3) ? RD_TX_STAT : RD_TX_PTR, 8'(8'h60 + i)));
            chk_valids("b2b", exp_tx, 12'h000, 1'b0, 1'b0);
            tick;
            chk("b2b.cnt", 64'(outst_cnt), 64'(i + 1));
        end
        chk("b2b.rdy_full", 64'(u_rdreq.rdreq_rdy), 64'd0);
        tick;
        chk("b2b.rdy_full2", 64'(u_rdreq.rdreq_rdy), 64'd0);
        cpl_pulse;
        chk("b2b.cnt_after_cpl", 64'(outst_cnt), 64'd3);
        chk("b2b.rdy_after_cpl", 64'(u_rdreq.rdreq_rdy), 64'd1);
        u_disp.tx_rd_ready = '0;

        // TX code with channel 12 (one past the last) -> ERR, left holding
        accept("tx12", mk(10'd1, 4'hF, 4'd12, RD_TX_LEN, 8'h77));
        chk_valids("tx12", 12'h000, 12'h000, 1'b0, 1'b1);

        // Reset during HOLD
        rst = 1'b0;
        tick;
        chk_valids("midrst", 12'h000, 12'h000, 1'b0, 1'b0);
        chk("midrst.cnt", 64'(outst_cnt), 64'd0);
        chk("midrst.rdy", 64'(u_rdreq.rdreq_rdy), 64'd0);
        rst = 1'b1;
        #1;
        chk("midrst.rdy_release", 64'(u_rdreq.rdreq_rdy), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
